// File: rtl/detect_count_disp.sv
`default_nettype none
// ============================================================================
//  Module   : detect_count_disp
//  Purpose  : Counts step cycles on which the pattern detector output is high
//             into a 4-digit BCD total and drives that total onto a 4-digit
//             multiplexed, active-low 7-segment display.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SCAN_DIV  board-clock cycles per digit refresh slot (2 .. 2^20)
//  Ports
//    clki      in   board clock, all state on the rising edge
//    rst       in   asynchronous active-high reset
//    clko      in   slow step clock, asynchronous to clki
//    z         in   detector output, changes on clko rising edges
//    clr       in   synchronous clear of count and overflow flag
//    disp[7:0] out  segments, active-low, [0]=a .. [6]=g, [7]=dp
//    an[3:0]   out  digit enables, active-low one-hot, [0] = LS digit
//    bcd[15:0] out  current count, four BCD nibbles, [3:0] = LS digit
//    ovf       out  sticky wrap flag (9999 -> 0000)
//  Build options
//    DISP_LZB_EN  when defined, leading zeros on digits 3..1 are blanked
// ============================================================================
module detect_count_disp #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clki,
    input  logic        rst,
    input  logic        clko,
    input  logic        z,
    input  logic        clr,
    output logic [7:0]  disp,
    output logic [3:0]  an,
    output logic [15:0] bcd,
    output logic        ovf
);

    localparam int            CW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] c_SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [7:0]    c_SEG_OFF   = 8'hFF;

    // ------------------------------------------------------------------------
    // Input synchronisers. r_c3 keeps the previous synchronised clko so the
    // falling edge can be detected; z is sampled mid-period on that edge.
    // ------------------------------------------------------------------------
    logic r_c1, r_c2, r_c3;
    logic r_z1, r_z2;

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_c1 <= 1'b0;
            r_c2 <= 1'b0;
            r_c3 <= 1'b0;
            r_z1 <= 1'b0;
            r_z2 <= 1'b0;
        end else begin
            r_c1 <= clko;
            r_c2 <= r_c1;
            r_c3 <= r_c2;
            r_z1 <= z;
            r_z2 <= r_z1;
        end
    end

    logic w_step;
    logic w_inc;

    assign w_step = r_c3 & ~r_c2;
    assign w_inc  = w_step & r_z2;

    // ------------------------------------------------------------------------
    // BCD increment: ripple the carry through the four digits. A carry that
    // survives past digit 3 means the count wrapped 9999 -> 0000.
    // ------------------------------------------------------------------------
    logic [15:0] r_bcd;
    logic        r_ovf;
    logic [15:0] w_inc_bcd;
    logic        w_carry;

    always_comb begin
        w_carry   = 1'b1;
        w_inc_bcd = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == 4'd9) begin
                    w_inc_bcd[4*i +: 4] = 4'd0;
                end else begin
                    w_inc_bcd[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_bcd <= 16'h0000;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_bcd <= 16'h0000;
            r_ovf <= 1'b0;
        end else if (w_inc) begin
            r_bcd <= w_inc_bcd;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bcd = r_bcd;
    assign ovf = r_ovf;

    // ------------------------------------------------------------------------
    // Segment encoding, active-low, dp always off.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = c_SEG_OFF;
        endcase
        return s;
    endfunction

    logic [7:0] w_seg [4];

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_digit
`ifdef DISP_LZB_EN
        // A digit is blank while it and every more-significant digit are
        // zero; the least significant digit always shows.
        logic w_blank;
        assign w_blank    = (gi != 0) && (r_bcd[15:4*gi] == '0);
        assign w_seg[gi]  = w_blank ? c_SEG_OFF : seg_enc(r_bcd[4*gi +: 4]);
`else
        assign w_seg[gi]  = seg_enc(r_bcd[4*gi +: 4]);
`endif
    end

    // ------------------------------------------------------------------------
    // Refresh scan. The display flops load the index the scan is moving to,
    // so each digit is enabled for exactly SCAN_DIV cycles, and the segment
    // pattern is reloaded every cycle so count changes show one edge later.
    // ------------------------------------------------------------------------
    logic [CW-1:0] r_scan;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [7:0]    r_disp;
    logic          w_scan_last;
    logic [1:0]    w_next_idx;

    assign w_scan_last = (r_scan == c_SCAN_LAST);
    assign w_next_idx  = w_scan_last ? (r_idx + 2'd1) : r_idx;

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_idx  <= 2'd0;
            r_an   <= 4'b1110;
            r_disp <= 8'hC0;
        end else begin
            r_scan <= w_scan_last ? '0 : (r_scan + CW'(1));
            r_idx  <= w_next_idx;
            r_an   <= ~(4'b0001 << w_next_idx);
            r_disp <= w_seg[w_next_idx];
        end
    end

    assign an   = r_an;
    assign disp = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_detect_count_disp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_detect_count_disp
//  Purpose  : Directed self-checking bench for detect_count_disp (SCAN_DIV=4)
//  Revision : 1.0  - initial release
// ============================================================================
module tb_detect_count_disp;

    logic        clki;
    logic        rst;
    logic        clko;
    logic        z;
    logic        clr;
    logic [7:0]  disp;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        ovf;
    logic        clk_en;

    int vectors     = 0;
    int miscompares = 0;
    int cnt         = 0;

    detect_count_disp #(.SCAN_DIV(4)) dut (
        .clki (clki),
        .rst  (rst),
        .clko (clko),
        .z    (z),
        .clr  (clr),
        .disp (disp),
        .an   (an),
        .bcd  (bcd),
        .ovf  (ovf)
    );

    initial begin
        clki = 1'b0;
        forever begin
            #5;
            if (clk_en) clki = ~clki;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_disp(input int idx, input int n);
        int p;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
`ifdef DISP_LZB_EN
        if (idx > 0 && n < p) return 8'hFF;
`endif
        return seg_of((n / p) % 10);
    endfunction

    // Called at a falling clki edge; returns at a falling clki edge.
    task automatic step(input logic zv, input int hi, input int lo);
        clko = 1'b1;
        z    = zv;
        repeat (hi) @(negedge clki);
        clko = 1'b0;
        repeat (lo) @(negedge clki);
    endtask

    // Align to the start of digit 0's slot and check one full refresh frame.
    task automatic scan_check(input string tag, input int n);
        logic [3:0] prev;
        logic [3:0] exp_an;
        bit         found;
        int         waited;
        found  = 1'b0;
        waited = 0;
        prev   = an;
        while (!found && waited < 40) begin
            @(posedge clki); #1;
            if (prev == 4'h7 && an == 4'hE) found = 1'b1;
            else begin
                prev = an;
                waited++;
            end
        end
        chk({tag, "_sync"}, 32'(found), 32'd1);
        if (found) begin
            for (int k = 0; k < 16; k++) begin
                if (k > 0) begin
                    @(posedge clki); #1;
                end
                exp_an = ~(4'b0001 << (k / 4));
                chk({tag, "_an"}, 32'(an), 32'(exp_an));
                chk({tag, "_disp"}, 32'(disp), 32'(exp_disp(k / 4, n)));
            end
        end
        @(negedge clki);
    endtask

    initial begin
        logic [12:0] pat;
        clk_en = 1'b0;
        rst    = 1'b0;
        clko   = 1'b0;
        z      = 1'b0;
        clr    = 1'b0;

        // Reset with the clock stopped.
        #2 rst = 1'b1;
        #1;
        chk("rst_bcd",  32'(bcd),  32'h0000);
        chk("rst_ovf",  32'(ovf),  32'h0);
        chk("rst_an",   32'(an),   32'hE);
        chk("rst_disp", 32'(disp), 32'hC0);
        clk_en = 1'b1;
        repeat (3) @(posedge clki);
        @(negedge clki);
        rst = 1'b0;

        // 13 slow periods, z high on 7 of them.
        pat = 13'b1011010011010;
        for (int k = 0; k < 13; k++) begin
            step(pat[k], 8, 8);
            if (pat[k]) cnt++;
        end
        chk("count13", 32'(bcd), 32'h0007);

        // Latency: increment lands on the third rising edge after the fall.
        clko = 1'b1;
        z    = 1'b1;
        repeat (8) @(negedge clki);
        clko = 1'b0;
        @(posedge clki); #1;
        chk("lat_e1", 32'(bcd), 32'h0007);
        @(posedge clki); #1;
        chk("lat_e2", 32'(bcd), 32'h0007);
        @(posedge clki); #1;
        chk("lat_e3", 32'(bcd), 32'h0008);
        cnt = 8;
        repeat (5) @(negedge clki);

        // A step with z low does not count.
        step(1'b0, 3, 3);
        chk("z_low", 32'(bcd), 32'h0008);

        while (cnt < 42) begin
            step(1'b1, 3, 3);
            cnt++;
        end
        chk("bcd42", 32'(bcd), 32'h0042);
        scan_check("blank42", 42);

        while (cnt < 99) begin
            step(1'b1, 3, 3);
            cnt++;
        end
        chk("bcd99", 32'(bcd), 32'h0099);
        step(1'b1, 3, 3);
        cnt++;
        chk("carry100", 32'(bcd), 32'h0100);

        while (cnt < 1234) begin
            step(1'b1, 3, 3);
            cnt++;
        end
        chk("bcd1234", 32'(bcd), 32'h1234);
        scan_check("scan1234", 1234);

        while (cnt < 9999) begin
            step(1'b1, 3, 3);
            cnt++;
        end
        chk("bcd9999",   32'(bcd), 32'(to_bcd(cnt)));
        chk("ovf9999",   32'(ovf), 32'h0);
        step(1'b1, 3, 3);
        chk("wrap_bcd",  32'(bcd), 32'h0000);
        chk("wrap_ovf",  32'(ovf), 32'h1);
        step(1'b0, 3, 3);
        chk("ovf_stick", 32'(ovf), 32'h1);

        clr = 1'b1;
        @(negedge clki);
        clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'h0);
        chk("clr_bcd", 32'(bcd), 32'h0000);

        // Clear coinciding with an increment wins.
        repeat (5) step(1'b1, 3, 3);
        chk("bcd5", 32'(bcd), 32'h0005);
        clko = 1'b1;
        z    = 1'b1;
        repeat (8) @(negedge clki);
        clko = 1'b0;
        @(negedge clki);
        @(negedge clki);
        clr = 1'b1;
        @(negedge clki);
        clr = 1'b0;
        chk("clrpri_bcd", 32'(bcd), 32'h0000);
        repeat (4) @(negedge clki);
        chk("clrpri_hold", 32'(bcd), 32'h0000);

        // Reset mid-operation, then digit 0 gets a full slot first.
        repeat (2) step(1'b1, 3, 3);
        chk("bcd2", 32'(bcd), 32'h0002);
        #2 rst = 1'b1;
        #1;
        chk("mid_bcd",  32'(bcd),  32'h0000);
        chk("mid_an",   32'(an),   32'hE);
        chk("mid_disp", 32'(disp), 32'hC0);
        @(negedge clki);
        rst = 1'b0;
        repeat (3) @(posedge clki);
        #1;
        chk("resume_an0", 32'(an), 32'hE);
        @(posedge clki); #1;
        chk("resume_an1", 32'(an), 32'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
